// File: rtl/text_pkg.sv
// Shared constants, host-FSM state type and the glyph table used by the text overlay.
package text_pkg;

    localparam logic [1:0] CMD_PUT     = 2'b00;
    localparam logic [1:0] CMD_SET     = 2'b01;
    localparam logic [1:0] CMD_CLEAR   = 2'b10;
    localparam logic [1:0] CMD_NEWLINE = 2'b11;

    localparam int         FONT_W      = 8;
    localparam int         FONT_H      = 16;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic {ST_IDLE, ST_CLEAR} host_state_e;

    localparam logic [7:0] GLYPH_A [FONT_H] = '{
        8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
        8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Glyph subset of the 8x16 table; codes without an entry render blank. MSB is the leftmost pixel.
    function automatic logic [7:0] font_row(input logic [6:0] code, input logic [3:0] row);
        case (code)
            7'h41:   font_row = GLYPH_A[row];
            7'h7F:   font_row = 8'hFF;
            default: font_row = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/text_char_ram.sv
// Character buffer: one write port, one synchronous read port, read-first on collisions.
module text_char_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [6:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [6:0]    rdata
);

    logic [6:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_overlay_renderer.sv
// Text-mode overlay: 3-stage pixel pipeline over a host-written character buffer,
// with scaling, a blinking cursor and a small command FSM for the host port.
module text_overlay_renderer
    import text_pkg::*;
#(
    parameter int          COLS       = 32,
    parameter int          ROWS       = 4,
    parameter int          X0         = 192,
    parameter int          Y0         = 208,
    parameter int          SCALE_LOG2 = 0,
    parameter logic [11:0] FG         = 12'h00F,
    parameter logic [11:0] BG         = 12'hFFF,
    parameter int          BLINK_BITS = 24,
    localparam int         CW         = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int         RW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          video_on,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [1:0]    wr_cmd,
    input  logic [15:0]   wr_data,
    input  logic          cursor_en,
    output logic [CW-1:0] cur_col,
    output logic [RW-1:0] cur_row,
    output logic [11:0]   rgb,
    output logic          video_on_q
);

    localparam int         CELLS = COLS * ROWS;
    localparam int         AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int         WIN_W = (COLS * FONT_W) << SCALE_LOG2;
    localparam int         WIN_H = (ROWS * FONT_H) << SCALE_LOG2;
    localparam int         BW    = BLINK_BITS + 1;
    localparam logic [7:0] ROWS8 = 8'(ROWS);
    localparam logic [7:0] COLS8 = 8'(COLS);

    host_state_e   state_q, state_d;
    logic [CW-1:0] cur_col_q, cur_col_d;
    logic [RW-1:0] cur_row_q, cur_row_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    // One bit wider than BLINK_BITS so the MSB holds each phase for 2**BLINK_BITS clk.
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;

    logic [2:0]    vld_pipe_q, vld_pipe_d;
    logic          s1_in_win_q, s1_in_win_d, s2_in_win_q, s2_in_win_d;
    logic [2:0]    s1_dx_q, s1_dx_d, s2_dx_q, s2_dx_d;
    logic [3:0]    s1_dy_q, s1_dy_d;
    logic [AW-1:0] s1_cell_q, s1_cell_d, s2_cell_q, s2_cell_d;
    logic [7:0]    font_q, font_d;
    logic [11:0]   rgb_q, rgb_d;

    logic [11:0]   xr, yr, dx_full, dy_full;
    logic          in_win, font_bit, cur_hit;
    logic [2:0]    bit_idx;
    logic [AW-1:0] rd_addr, cur_cell, ram_waddr;
    logic [6:0]    char_code, ram_wdata;
    logic          ram_we;

    text_char_ram #(.DEPTH(CELLS), .AW(AW)) u_char_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(rd_addr),
        .rdata(char_code)
    );

    always_comb begin
        cur_cell = AW'(32'(cur_row_q) * COLS + 32'(cur_col_q));
        xr       = {2'b00, x} - 12'(X0);
        yr       = {2'b00, y} - 12'(Y0);
        in_win   = ({2'b00, x} >= 12'(X0)) && ({2'b00, x} < 12'(X0 + WIN_W)) &&
                   ({2'b00, y} >= 12'(Y0)) && ({2'b00, y} < 12'(Y0 + WIN_H));
        dx_full  = xr >> SCALE_LOG2;
        dy_full  = yr >> SCALE_LOG2;
        // Out-of-window pixels read cell 0; the result is masked by in_win downstream.
        rd_addr  = in_win ? AW'(32'(dy_full[11:4]) * COLS + 32'(dx_full[11:3])) : '0;

        vld_pipe_d  = {vld_pipe_q[1:0], video_on};
        s1_in_win_d = in_win;
        s1_dx_d     = dx_full[2:0];
        s1_dy_d     = dy_full[3:0];
        s1_cell_d   = rd_addr;

        font_d      = font_row(char_code, s1_dy_q);
        s2_in_win_d = s1_in_win_q;
        s2_dx_d     = s1_dx_q;
        s2_cell_d   = s1_cell_q;

        bit_idx  = ~s2_dx_q;
        cur_hit  = cursor_en && blink_cnt_q[BW-1] && (s2_cell_q == cur_cell);
        font_bit = s2_in_win_q && (font_q[bit_idx] ^ cur_hit);
        rgb_d    = !vld_pipe_q[1] ? 12'h000 : (font_bit ? FG : BG);

        blink_cnt_d = blink_cnt_q + BW'(1);
    end

    always_comb begin
        state_d   = state_q;
        cur_col_d = cur_col_q;
        cur_row_d = cur_row_q;
        clr_cnt_d = clr_cnt_q;
        ram_we    = 1'b0;
        ram_waddr = cur_cell;
        ram_wdata = wr_data[6:0];
        wr_ready  = (state_q == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (wr_valid) begin
                    case (wr_cmd)
                        CMD_PUT: begin
                            ram_we = 1'b1;
                            if (cur_col_q == CW'(COLS - 1)) begin
                                cur_col_d = '0;
                                cur_row_d = (cur_row_q == RW'(ROWS - 1)) ? '0 : cur_row_q + RW'(1);
                            end else begin
                                cur_col_d = cur_col_q + CW'(1);
                            end
                        end
                        CMD_SET: begin
                            if ((wr_data[15:8] < ROWS8) && (wr_data[7:0] < COLS8)) begin
                                cur_row_d = RW'(wr_data[15:8]);
                                cur_col_d = CW'(wr_data[7:0]);
                            end
                        end
                        CMD_CLEAR: begin
                            state_d   = ST_CLEAR;
                            clr_cnt_d = '0;
                        end
                        CMD_NEWLINE: begin
                            cur_col_d = '0;
                            cur_row_d = (cur_row_q == RW'(ROWS - 1)) ? '0 : cur_row_q + RW'(1);
                        end
                        default: ;
                    endcase
                end
            end
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_wdata = ASCII_SPACE[6:0];
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(CELLS - 1)) begin
                    state_d   = ST_IDLE;
                    cur_col_d = '0;
                    cur_row_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_col_q   <= '0;
            cur_row_q   <= '0;
            clr_cnt_q   <= '0;
            blink_cnt_q <= '0;
            vld_pipe_q  <= '0;
            s1_in_win_q <= 1'b0;
            s1_dx_q     <= '0;
            s1_dy_q     <= '0;
            s1_cell_q   <= '0;
            s2_in_win_q <= 1'b0;
            s2_dx_q     <= '0;
            s2_cell_q   <= '0;
            font_q      <= '0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_col_q   <= cur_col_d;
            cur_row_q   <= cur_row_d;
            clr_cnt_q   <= clr_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            vld_pipe_q  <= vld_pipe_d;
            s1_in_win_q <= s1_in_win_d;
            s1_dx_q     <= s1_dx_d;
            s1_dy_q     <= s1_dy_d;
            s1_cell_q   <= s1_cell_d;
            s2_in_win_q <= s2_in_win_d;
            s2_dx_q     <= s2_dx_d;
            s2_cell_q   <= s2_cell_d;
            font_q      <= font_d;
            rgb_q       <= rgb_d;
        end
    end

    assign cur_col    = cur_col_q;
    assign cur_row    = cur_row_q;
    assign rgb        = rgb_q;
    assign video_on_q = vld_pipe_q[2];

endmodule

// File: tb/tb_text_overlay_renderer.sv
// Directed bench: one unscaled and one 2x-scaled overlay sharing all inputs.
module tb_text_overlay_renderer;

    localparam logic [11:0] FG = 12'h00F;
    localparam logic [11:0] BG = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst, video_on, wr_valid, cursor_en;
    logic [9:0]  x, y;
    logic [1:0]  wr_cmd;
    logic [15:0] wr_data;

    logic        ready_a, ready_b, vq_a, vq_b;
    logic [4:0]  col_a, col_b;
    logic [1:0]  row_a, row_b;
    logic [11:0] rgb_a, rgb_b;

    int total = 0;
    int bad   = 0;

    logic [7:0] glyph_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    text_overlay_renderer #(.SCALE_LOG2(0), .BLINK_BITS(4)) u_a (
        .clk(clk), .rst(rst), .video_on(video_on), .x(x), .y(y),
        .wr_valid(wr_valid), .wr_ready(ready_a), .wr_cmd(wr_cmd), .wr_data(wr_data),
        .cursor_en(cursor_en), .cur_col(col_a), .cur_row(row_a),
        .rgb(rgb_a), .video_on_q(vq_a)
    );

    text_overlay_renderer #(.SCALE_LOG2(1), .BLINK_BITS(4)) u_b (
        .clk(clk), .rst(rst), .video_on(video_on), .x(x), .y(y),
        .wr_valid(wr_valid), .wr_ready(ready_b), .wr_cmd(wr_cmd), .wr_data(wr_data),
        .cursor_en(cursor_en), .cur_col(col_b), .cur_row(row_b),
        .rgb(rgb_b), .video_on_q(vq_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [15:0] d);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_cmd   = c;
        wr_data  = d;
        while (!ready_a && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) chk("send_timeout", 0, 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pix(input int px, input int py, input logic vo);
        x = 10'(px);
        y = 10'(py);
        video_on = vo;
        repeat (3) tick();
    endtask

    initial begin
        int lowcnt, nt, acc, fgcnt;
        int tr[3];
        logic [11:0] s [80];
        logic [7:0]  rowbits;

        rst = 1'b1; video_on = 1'b0; x = '0; y = '0;
        wr_valid = 1'b0; wr_cmd = '0; wr_data = '0; cursor_en = 1'b0;
        #23 rst = 1'b0;
        tick();
        chk("rst_rgb", rgb_a, 0);
        chk("rst_vq", vq_a, 0);
        chk("rst_ready", ready_a, 1);
        chk("rst_col", col_a, 0);
        chk("rst_row", row_a, 0);

        // Seed a block at cell 3, then CLEAR with a PUT queued behind it
        send(2'b01, 16'h0003);
        chk("set_col3", col_a, 3);
        send(2'b00, 16'h007F);
        chk("put_col4", col_a, 4);
        pix(218, 210, 1'b1);
        chk("blk_before_clr", rgb_a, FG);

        wr_valid = 1'b1; wr_cmd = 2'b10; wr_data = '0;
        tick();
        wr_cmd = 2'b00; wr_data = 16'h0041;
        lowcnt = 0;
        while (!ready_a && lowcnt < 1000) begin
            tick();
            lowcnt++;
        end
        chk("clr_low_cycles", lowcnt, 128);
        tick();
        wr_valid = 1'b0;
        chk("put_after_clr_col", col_a, 1);
        chk("put_after_clr_row", row_a, 0);
        pix(218, 210, 1'b1);
        chk("blk_cleared", rgb_a, BG);
        pix(192 + 248 + 3, 208 + 48 + 5, 1'b1);
        chk("last_cell_cleared", rgb_a, BG);

        // Latency: hold an outside pixel, then step onto a lit 'A' pixel
        pix(100, 100, 1'b1);
        chk("outside_bg", rgb_a, BG);
        x = 10'd195; y = 10'd211;
        tick(); tick();
        chk("lat_2clk_old", rgb_a, BG);
        tick();
        chk("lat_3clk_new", rgb_a, FG);
        chk("lat_vq", vq_a, 1);

        for (int r = 0; r < 16; r++) begin
            rowbits = glyph_a[r];
            for (int c = 0; c < 8; c++) begin
                pix(192 + c, 208 + r, 1'b1);
                chk($sformatf("glyphA_r%0d_c%0d", r, c), rgb_a, rowbits[7 - c] ? FG : BG);
            end
        end

        // 2x scaling on u_b
        pix(192, 208, 1'b1); chk("s1_192_208", rgb_b, BG);
        pix(193, 209, 1'b1); chk("s1_193_209", rgb_b, BG);
        pix(198, 214, 1'b1); chk("s1_198_214", rgb_b, FG);
        pix(199, 215, 1'b1); chk("s1_199_215", rgb_b, FG);
        pix(196, 212, 1'b1); chk("s1_196_212", rgb_b, BG);
        chk("s0_196_212", rgb_a, FG);
        pix(704, 210, 1'b1); chk("s1_x704_bg", rgb_b, BG);

        // Cursor motion
        send(2'b01, 16'h0000);
        for (int i = 0; i < 33; i++) send(2'b00, 16'h007F);
        chk("put33_col", col_a, 1);
        chk("put33_row", row_a, 1);
        for (int i = 0; i < 95; i++) send(2'b00, 16'h007F);
        chk("put128_col", col_a, 0);
        chk("put128_row", row_a, 0);
        send(2'b01, 16'h0700);
        chk("set_row7_col", col_a, 0);
        chk("set_row7_row", row_a, 0);
        send(2'b01, 16'h0028);
        chk("set_col40_col", col_a, 0);
        send(2'b01, 16'h0205);
        chk("set_2_5_col", col_a, 5);
        chk("set_2_5_row", row_a, 2);
        send(2'b11, 16'h0000);
        chk("nl_col", col_a, 0);
        chk("nl_row", row_a, 3);
        send(2'b11, 16'h0000);
        chk("nl_wrap_row", row_a, 0);

        // Blink on cell 0 (full block everywhere)
        cursor_en = 1'b1;
        pix(194, 210, 1'b1);
        for (int i = 0; i < 80; i++) begin
            s[i] = rgb_a;
            tick();
        end
        nt = 0;
        tr = '{-1, -1, -1};
        for (int i = 1; i < 80; i++) begin
            if (s[i] != s[i - 1] && nt < 3) begin
                tr[nt] = i;
                nt++;
            end
        end
        chk("blink_run1", tr[1] - tr[0], 16);
        chk("blink_run2", tr[2] - tr[1], 16);
        chk("blink_inv_bg", int'(tr[0] >= 0 && (s[tr[0]] == BG || s[tr[1] >= 0 ? tr[1] : 0] == BG)), 1);
        pix(202, 210, 1'b1);
        fgcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (rgb_a == FG) fgcnt++;
            tick();
        end
        chk("noncursor_steady", fgcnt, 40);
        pix(194, 210, 1'b0);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            acc = acc | int'(rgb_a);
            tick();
        end
        chk("vid_off_rgb", acc, 0);
        chk("vid_off_vq", vq_a, 0);
        cursor_en = 1'b0;

        // Async reset in the middle of a CLEAR
        pix(194, 210, 1'b1);
        send(2'b01, 16'h0102);
        send(2'b10, 16'h0000);
        repeat (10) tick();
        chk("clr_busy", ready_a, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_rgb", rgb_a, 0);
        chk("arst_ready", ready_a, 1);
        chk("arst_col", col_a, 0);
        chk("arst_row", row_a, 0);
        chk("arst_vq", vq_a, 0);
        #3 rst = 1'b0;
        tick();
        chk("post_rst_ready", ready_a, 1);
        pix(354, 210, 1'b1);
        chk("partial_keep", rgb_a, FG);
        pix(210, 210, 1'b1);
        chk("partial_cleared", rgb_a, BG);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
